// File: rtl/popcount_100b.sv
// popcount_100b: 100-bit population count, combinational result plus a 1-cycle registered copy.
// Optional is_zero/is_full flags when POPCOUNT_FLAGS_EN is defined.
module popcount_100b (
    input  logic        clk,
    input  logic        reset,
    input  logic [99:0] in_,
    output logic [6:0]  out,
    output logic [6:0]  out_q
`ifdef POPCOUNT_FLAGS_EN
    ,
    output logic        is_zero,
    output logic        is_full
`endif
);
    localparam int WIDTH = 100;
    localparam int CNT_W = 7;
    logic [2:0]       l0 [25];
    logic [3:0]       l1 [13];
    logic [4:0]       l2 [7];
    logic [5:0]       l3 [4];
    logic [CNT_W-1:0] l4 [2];
    for (genvar i = 0; i < 25; i++) begin : g_l0
        assign l0[i] = 3'(in_[4*i]) + 3'(in_[4*i+1]) + 3'(in_[4*i+2]) + 3'(in_[4*i+3]);
    end
    for (genvar i = 0; i < 12; i++) begin : g_l1
        assign l1[i] = 4'(l0[2*i]) + 4'(l0[2*i+1]);
    end
    assign l1[12] = 4'(l0[24]);
    for (genvar i = 0; i < 6; i++) begin : g_l2
        assign l2[i] = 5'(l1[2*i]) + 5'(l1[2*i+1]);
    end
    assign l2[6] = 5'(l1[12]);
    for (genvar i = 0; i < 3; i++) begin : g_l3
        assign l3[i] = 6'(l2[2*i]) + 6'(l2[2*i+1]);
    end
    assign l3[3] = 6'(l2[6]);
    for (genvar i = 0; i < 2; i++) begin : g_l4
        assign l4[i] = 7'(l3[2*i]) + 7'(l3[2*i+1]);
    end
    // Final sum peaks at 100, so 7 bits never wrap.
    assign out = l4[0] + l4[1];
    always_ff @(posedge clk)
        out_q <= !reset ? '0 : out;
`ifdef POPCOUNT_FLAGS_EN
    assign is_zero = (out == '0);
    assign is_full = (out == CNT_W'(WIDTH));
`endif
endmodule

// File: tb/tb_popcount_100b.sv
// tb_popcount_100b: directed and random checks of popcount_100b against a bit-loop reference count.
module tb_popcount_100b;
    logic        clk = 0;
    logic        reset;
    logic [99:0] in_;
    logic [6:0]  out, out_q;
    int          total = 0, passed = 0;
    logic [99:0] v;
    logic [127:0] r;
`ifdef POPCOUNT_FLAGS_EN
    logic is_zero, is_full;
    popcount_100b dut (.clk(clk), .reset(reset), .in_(in_), .out(out), .out_q(out_q),
                       .is_zero(is_zero), .is_full(is_full));
`else
    popcount_100b dut (.clk(clk), .reset(reset), .in_(in_), .out(out), .out_q(out_q));
`endif
    always #5 clk = ~clk;

    function automatic int ref_pop(input logic [99:0] x);
        int n = 0;
        for (int b = 0; b < 100; b++) n += int'(x[b]);
        return n;
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic comb(input logic [99:0] x, input int exp, input string tag);
        in_ = x;
        #1;
        check(tag, out, 7'(exp));
        check({tag, "_ref"}, out, 7'(ref_pop(x)));
`ifdef POPCOUNT_FLAGS_EN
        check({tag, "_zero"}, 7'(is_zero), 7'(exp == 0));
        check({tag, "_full"}, 7'(is_full), 7'(exp == 100));
`endif
    endtask

    task automatic edge_q();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        in_ = '0;
        comb('0, 0, "zero_in_reset");
        edge_q();
        check("q_reset_init", out_q, 7'd0);
        for (int k = 0; k < 8; k++) comb(100'(1) << k, 1, $sformatf("single_%0d", k));
        comb(100'h03, 2, "p03");
        comb(100'h0E, 3, "p0E");
        comb(100'h3C, 4, "p3C");
        comb(100'hF8, 5, "pF8");
        comb(100'hFF, 8, "pFF");
        v = '0;
        for (int k = 0; k < 25; k++) begin
            v = v | (100'h1 << (4 * k));
            comb(v, k + 1, $sformatf("ones_%0d", k + 1));
        end
        v = '0;
        for (int k = 0; k < 25; k++) v = v | (100'h3 << (4 * k));
        comb(v, 50, "all_3");
        v = '0;
        for (int k = 0; k < 25; k++) v = v | (100'h7 << (4 * k));
        comb(v, 75, "all_7");
        comb({100{1'b1}}, 100, "all_F");
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            in_ = r[99:0];
            #1;
            check($sformatf("rand_%0d", k), out, 7'(ref_pop(r[99:0])));
            edge_q();
            check($sformatf("rand_q_%0d", k), out_q, 7'(ref_pop(r[99:0])));
        end
        reset = 1'b0;
        in_ = {100{1'b1}};
        for (int k = 0; k < 2; k++) begin
            edge_q();
            check("hold_rst_q", out_q, 7'd0);
            check("hold_rst_out", out, 7'd100);
        end
        reset = 1'b1;
        edge_q();
        check("release_q", out_q, 7'd100);
        in_ = 100'h3;
        #1;
        check("chg_out", out, 7'd2);
        check("chg_q_before", out_q, 7'd100);
        edge_q();
        check("chg_q_after", out_q, 7'd2);
        in_ = 100'hFF;
        edge_q();
        check("mid_pre_q", out_q, 7'd8);
        reset = 1'b0;
        edge_q();
        check("mid_rst_q", out_q, 7'd0);
        check("mid_rst_out", out, 7'd8);
        reset = 1'b1;
        edge_q();
        check("mid_release_q", out_q, 7'd8);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/popcount_100b.md
Name: popcount_100b

Overview:
- Population-count block: reports how many bits of a 100-bit input vector are set.
- Primary result is purely combinational, for use inside single-cycle datapath logic (mask occupancy, valid-bit counting).
- Also provides a registered copy of the count for timing-critical consumers; this copy is on the single clock domain.

Parameters:
- WIDTH, 100, input vector width; only 100 is required to be verified.
- CNT_W, 7, count width = ceil(log2(WIDTH+1)); must hold values 0..WIDTH.

Ports:
- clk      input   1      single clock; rising edge active
- reset    input   1      synchronous, active-low reset (asserted when 0, sampled on rising clk)
- in_      input   100    vector to count; bit 0 is LSB
- out      output  7      combinational count of ones in in_
- out_q    output  7      registered count; value of out sampled at previous rising edge

Behaviour:
- out = number of bits equal to 1 in in_[99:0], unsigned, range 0..100.
  - Zero latency, no clock dependence; settles within the same cycle in_ changes.
  - Unaffected by reset.
- Width rule: result is zero-extended into 7 bits; max value 100 (7'h64); never wraps.
- Narrower stimulus driven onto in_ is zero-extended by the driver; only bits actually set count.
- Required structure: balanced adder/compressor tree.
  - Level 0: 25 nibble counters (0..4, 3 bits each).
  - Subsequent levels sum pairs with widening (4, 5, 6, 7 bits); odd leftover terms pass through zero-extended.
  - No sequential logic in the out path.
- out_q:
  - On rising clk with reset==0: out_q <= 0.
  - Otherwise: out_q <= out.
  - Latency exactly 1 cycle; updates every cycle, no enable.
- Reset value of out_q is 0. out has no reset value; it always reflects in_.
- Reset mid-operation: out_q clears on the next edge where reset is low. Normal tracking resumes on the first edge with reset high, capturing the then-current out.
- X on any in_ bit may propagate X to out; no X-masking required.

Optional Feature:
- Macro: POPCOUNT_FLAGS_EN.
- When defined, adds two combinational 1-bit outputs:
  - is_zero = (out == 0)
  - is_full = (out == WIDTH)
- Both are derived from the same tree result, not from a separate reduction.
- When undefined, both ports and their logic are absent. Module interface is then exactly as listed above.

Test Plan:
- in_=0 -> out=0. Then single-bit vectors 0x1, 0x2, 0x4 ... 0x80 -> out=1 each.
- Small patterns: 0x03 -> 2; 0x0E -> 3; 0x3C -> 4; 0xF8 -> 5; 0xFF -> 8.
- Growing hex-digit patterns, each digit 0x1:
  - 0x1 -> 1; 0x11 -> 2; 0x111 -> 3 ... up to 100'h1_1111_1111_1111_1111_1111_1111 -> 25.
  - 100'h3_3333...3333 -> 50.
  - 100'h7_7777...7777 -> 75.
  - 100'hF_FFFF...FFFF -> 100 (7'h64, no overflow).
  - With POPCOUNT_FLAGS_EN: is_full=1 only for the all-ones case; is_zero=1 only for in_=0.
- 20 random 100-bit vectors (four concatenated 32-bit randoms, truncated) -> out equals software popcount of the low 100 bits, checked each cycle.
- Registered path:
  - Hold reset=0 for 2 cycles with in_=all-ones -> out_q=0 while out=100.
  - Release reset -> out_q=100 after first edge.
  - Change in_ to 0x3 -> out=2 immediately, out_q=2 one edge later.
- Mid-stream reset: drive in_=0xFF, reset low for one edge -> out_q=0 that cycle, out stays 8. Release -> out_q=8 next edge.
